// File: rtl/fib_sequencer.sv
// Fibonacci sequencer: drives an external register file (R0=a, R1=b, R2=temp)
// through an init/add/move loop and captures F(n) mod 2^DATA_WIDTH.
module fib_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  n_terms,
   input  logic [15:0]           rf_rdata1,
   input  logic [15:0]           rf_rdata2,
   output logic [4:0]            rs,
   output logic [4:0]            rt,
   output logic [1:0]            rd,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  en_w,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] fib_out,
   output logic                  overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT0,
      S_INIT1,
      S_ADD,
      S_MOV_B,
      S_MOV_S,
      S_CAPTURE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [CNT_WIDTH-1:0]  w_cnt_dec;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  r_done;
   logic                  r_ovf;
   logic [DATA_WIDTH-1:0] r_fib;
   logic                  w_accept;

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_cnt_dec = r_cnt - CNT_WIDTH'(1);
   assign w_sum     = {1'b0, rf_rdata1[DATA_WIDTH-1:0]} + {1'b0, rf_rdata2[DATA_WIDTH-1:0]};

   // Upper read-data bits beyond DATA_WIDTH carry no meaning for this block.
   generate
      if (DATA_WIDTH < 16) begin : g_hi
         logic w_unused_hi;
         assign w_unused_hi = ^{rf_rdata1[15:DATA_WIDTH], rf_rdata2[15:DATA_WIDTH]};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_fib  <= '0;
      end else begin
         r_done <= (r_state == S_CAPTURE);
         if (w_accept) begin
            r_cnt <= n_terms;
            r_ovf <= 1'b0;
         end
         if (r_state == S_ADD && w_sum[DATA_WIDTH]) r_ovf <= 1'b1;
         if (r_state == S_MOV_S)                    r_cnt <= w_cnt_dec;
         if (r_state == S_CAPTURE)                  r_fib <= rf_rdata1[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      w_next = r_state;
      rs     = '0;
      rt     = '0;
      rd     = '0;
      wdata  = '0;
      en_w   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_INIT0;
         end
         S_INIT0: begin
            en_w   = 1'b1;
            w_next = S_INIT1;
         end
         S_INIT1: begin
            rd     = 2'd1;
            wdata  = DATA_WIDTH'(1);
            en_w   = 1'b1;
            w_next = (r_cnt == '0) ? S_CAPTURE : S_ADD;
         end
         S_ADD: begin
            rs     = 5'd0;
            rt     = 5'd1;
            rd     = 2'd2;
            wdata  = w_sum[DATA_WIDTH-1:0];
            en_w   = 1'b1;
            w_next = S_MOV_B;
         end
         S_MOV_B: begin
            rs     = 5'd1;
            wdata  = rf_rdata1[DATA_WIDTH-1:0];
            en_w   = 1'b1;
            w_next = S_MOV_S;
         end
         S_MOV_S: begin
            rs     = 5'd2;
            rd     = 2'd1;
            wdata  = rf_rdata1[DATA_WIDTH-1:0];
            en_w   = 1'b1;
            w_next = (w_cnt_dec == '0) ? S_CAPTURE : S_ADD;
         end
         S_CAPTURE: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign fib_out  = r_fib;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer with a behavioural register file whose
// upper read-data byte is junk the design must ignore.
module tb_fib_sequencer;

   localparam int DW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] n_terms = '0;
   logic [15:0]   rf_rdata1;
   logic [15:0]   rf_rdata2;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [1:0]    rd;
   logic [DW-1:0] wdata;
   logic          en_w;
   logic          busy;
   logic          done;
   logic [DW-1:0] fib_out;
   logic          overflow;

   logic [15:0]   rf [0:31];

   int n_vec = 0;
   int n_err = 0;

   fib_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .n_terms   (n_terms),
      .rf_rdata1 (rf_rdata1),
      .rf_rdata2 (rf_rdata2),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .wdata     (wdata),
      .en_w      (en_w),
      .busy      (busy),
      .done      (done),
      .fib_out   (fib_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 16'h5A5A;
   end

   always @(posedge clk) begin
      if (en_w) rf[rd] <= 16'hC300 | 16'(wdata);
   end

   assign rf_rdata1 = rf[rs];
   assign rf_rdata2 = rf[rt];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("rd_range", 32'(rd <= 2'd2), 1);
      check("en_w_only_busy", 32'(!en_w || busy), 1);
      if (!en_w) check("idle_bus_zero", 32'({rs, rt, rd, wdata}), 0);
   end

   // Called #1 after a rising edge; start is accepted on the next edge.
   task automatic run(input string tag, input int n, input int exp_fib, input int exp_ovf);
      int  edges;
      bit  seen;
      start   = 1'b1;
      n_terms = CW'(n);
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("%s_busy", tag), 32'(busy), 1);
      edges = 0;
      seen  = 0;
      while (!seen && edges < 3 * n + 20) begin
         @(posedge clk); #1;
         edges++;
         if (done) seen = 1;
      end
      check($sformatf("%s_latency", tag), edges, 3 * n + 3);
      check($sformatf("%s_fib", tag), 32'(fib_out), exp_fib);
      check($sformatf("%s_ovf", tag), 32'(overflow), exp_ovf);
      check($sformatf("%s_idle", tag), 32'(busy), 0);
      @(posedge clk); #1;
      check($sformatf("%s_done_pulse", tag), 32'(done), 0);
      check($sformatf("%s_fib_hold", tag), 32'(fib_out), exp_fib);
      check($sformatf("%s_ovf_hold", tag), 32'(overflow), exp_ovf);
   endtask

   initial begin
      int pulses;
      int ma, mb, mt, movf;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_en_w", 32'(en_w), 0);
      check("rst_bus", 32'({rs, rt, rd, wdata}), 0);
      check("rst_fib", 32'(fib_out), 0);
      check("rst_ovf", 32'(overflow), 0);
      reset = 1'b0;

      run("n0", 0, 0, 0);
      check("n0_R0", 32'(rf[0][7:0]), 0);
      check("n0_R1", 32'(rf[1][7:0]), 1);

      run("n10", 10, 55, 0);
      check("n10_R0", 32'(rf[0][7:0]), 55);
      check("n10_R1", 32'(rf[1][7:0]), 89);

      run("n14", 14, 121, 1);
      run("n5", 5, 5, 0);
      run("n1", 1, 1, 0);
      run("n12", 12, 144, 0);
      run("n13", 13, 233, 1);

      // start held high: back-to-back runs, n_terms disturbed while busy
      start   = 1'b1;
      n_terms = CW'(3);
      @(posedge clk); #1;
      pulses = 0;
      for (int e = 1; e <= 25; e++) begin
         @(posedge clk); #1;
         if (e == 2) n_terms = CW'(7);
         if (e == 8) n_terms = CW'(3);
         if (e == 13) check("held_restart_busy", 32'(busy), 1);
         if (done) begin
            pulses++;
            if (pulses == 1) check("held_first_edge", e, 12);
            if (pulses == 2) check("held_second_edge", e, 25);
            check("held_fib", 32'(fib_out), 2);
         end
      end
      start = 1'b0;
      check("held_pulses", pulses, 2);
      @(posedge clk); #1;
      check("held_idle", 32'(busy), 0);

      // reset during MOV_B of an n=6 run
      start   = 1'b1;
      n_terms = CW'(6);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("movb_en_w", 32'(en_w), 1);
      check("movb_rs", 32'(rs), 1);
      reset = 1'b1;
      #1;
      check("abort_en_w", 32'(en_w), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_fib", 32'(fib_out), 0);
      check("abort_done", 32'(done), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      run("n6", 6, 8, 0);

      ma = 0; mb = 1; movf = 0;
      for (int i = 0; i < 255; i++) begin
         mt = ma + mb;
         if (mt > 255) movf = 1;
         ma = mb;
         mb = mt % 256;
      end
      run("n255", 255, ma, movf);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
